seq0011_scan_ctrl: RTL and testbench
====================================

Name: seq0011_scan_ctrl

Overview:
- Controller that sequences the serial Moore "0011" detector across parallel words.
- Accepts a WORD_W-bit word over a valid/ready handshake and shifts it MSB-first, one bit per clock, into a detector core.
- Counts pattern matches and records the bit index where the first match completes.
- Sits between a parallel source (switch bank or register interface) and display/LED logic.

Parameters:
- WORD_W, 16, bits per scanned word; must be ≥ 4.
- CNT_W, 5, width of match_cnt and first_idx, i.e. clog2(WORD_W)+1; first_idx sentinel is all-ones.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset: 0 forces reset immediately, independent of clk_in.
- in_valid  input  1  word_in is valid.
- in_ready  output  1  controller can accept a word.
- word_in  input  WORD_W  word to scan; bit WORD_W-1 is scanned first (index 0).
- ser_bit  output  1  bit currently presented to the detector, for debug/LED.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when results are valid.
- match_cnt  output  CNT_W  number of "0011" occurrences in the last word.
- first_idx  output  CNT_W  scan index of the final '1' of the first match; all-ones if no match.

Behaviour:
- Reset (reset=0):
  - State IDLE, shift register 0, bit index 0.
  - in_ready=1, busy=0, done=0, ser_bit=0, match_cnt=0, first_idx=all-ones.
  - Detector core returns to its S0 state.
- FSM states: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch word_in, set index=0, synchronously clear the core to S0, clear match_cnt, set first_idx to all-ones, go to SHIFT.
- SHIFT:
  - busy=1, in_ready=0.
  - ser_bit = shreg MSB; core enable=1.
  - Each edge: shift shreg left by one and increment index.
  - After the edge that consumes index WORD_W-1 (WORD_W edges total), go to FLUSH.
- Counting:
  - The core output is Moore, so it asserts the cycle after the completing bit.
  - A registered flag en_d (core enable delayed one cycle) gates counting.
  - On each edge where en_d=1 and core dout=1: match_cnt += 1.
  - On that same edge, if first_idx is all-ones, load first_idx = index-1 (index of the completing bit).
- FLUSH:
  - busy=1, core enable=0, so the core holds its state.
  - This edge captures the match for the last bit; go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0; go to IDLE.
- Latency: the accept edge is E0; done is high in the cycle after edge E(WORD_W+1), i.e. 18 edges for WORD_W=16.
- Results: match_cnt and first_idx stay stable from DONE until the next accept edge.
- Words are independent: the core is cleared at every accept, so a pattern straddling two words never matches.
- in_valid while busy: ignored, not queued; the source must hold in_valid until in_ready.
- Back-to-back throughput: one word per WORD_W+3 cycles.
- Reset mid-scan: async abort to the reset values above. No done pulse; partial counts are discarded.
- match_cnt cannot overflow: at most WORD_W/4 matches.
- Detector core transitions (din 0 / din 1):
  - S0 → S1 / S0
  - S1 → S2 / S0
  - S2 → S2 / S3
  - S3 → S1 / S4
  - S4 → S1 / S0
  - dout = (state==S4).
  - When the core's en=0 it holds state; clr (synchronous) takes priority over en.

Decomposition:
- Shared package:
  - detector state encodings S0–S4 (3-bit);
  - controller state encodings IDLE/SHIFT/FLUSH/DONE (2-bit);
  - the all-ones first_idx sentinel as a constant.
- One sub-module: moore0011_core. Ports: clk_in, reset (async active-low), clr, en, din, dout. It holds the detector FSM above.
- The controller contains the handshake, shift register, index counter and result registers.

Test Plan:
- word_in=16'h3000 → done after 18 edges, match_cnt=1, first_idx=3.
- word_in=16'h3333 → match_cnt=4, first_idx=3.
- word_in=16'h0003 → match_cnt=1, first_idx=15; proves the FLUSH capture of the last bit.
- word_in=16'hFFFF → match_cnt=0, first_idx=5'h1F. Then 16'h0000 followed by 16'hC000 → second word gives match_cnt=0 (no cross-word match).
- in_valid held high with 16'h3333 continuously → a new accept every 19 cycles; in_ready=0 throughout SHIFT/FLUSH/DONE.
- Drive reset=0 mid-SHIFT (index 7) between clock edges → outputs reach reset values immediately, no done pulse. Next word 16'h3000 scans correctly (match_cnt=1).

Source files
------------

// File: rtl/seq0011_scan_ctrl_pkg.sv
// Shared types and constants for the "0011" word-scan controller and its
// serial Moore detector core.
package seq0011_scan_ctrl_pkg;

    // Default geometry: 16-bit words, 5-bit result fields (clog2(16)+1).
    localparam int DEF_WORD_W = 16;
    localparam int DEF_CNT_W  = 5;

    // "No match seen" marker for first_idx; all-ones at any width.
    localparam logic [DEF_CNT_W-1:0] FIRST_IDX_NONE = 5'h1F;

    // Serial detector states; S4 means "0011" just completed.
    typedef enum logic [2:0] {
        DET_S0 = 3'd0,
        DET_S1 = 3'd1,
        DET_S2 = 3'd2,
        DET_S3 = 3'd3,
        DET_S4 = 3'd4
    } det_state_t;

    // Word-scan controller states.
    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_SHIFT = 2'd1,
        CTRL_FLUSH = 2'd2,
        CTRL_DONE  = 2'd3
    } ctrl_state_t;

    // Detector transition for one consumed bit.
    function automatic det_state_t det_next(input det_state_t cur, input logic din);
        det_state_t nxt;
        case (cur)
            DET_S0:  nxt = din ? DET_S0 : DET_S1;
            DET_S1:  nxt = din ? DET_S0 : DET_S2;
            DET_S2:  nxt = din ? DET_S3 : DET_S2;
            DET_S3:  nxt = din ? DET_S4 : DET_S1;
            DET_S4:  nxt = din ? DET_S0 : DET_S1;
            default: nxt = DET_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq0011_scan_ctrl_core.sv
// Serial Moore "0011" detector. dout is high the cycle after the bit that
// completes the pattern. clr (synchronous) beats en; en=0 holds state.
module moore0011_core
    import seq0011_scan_ctrl_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    det_state_t state_r;
    det_state_t state_s;
    logic       dout_r;

    // Next-state selection: clear, then advance on enable, else hold.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = DET_S0;
        end else if (en) begin
            state_s = det_next(state_r, din);
        end else begin
            state_s = state_r;
        end
    end

    // State register with the Moore output registered alongside it.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r <= DET_S0;
            dout_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            dout_r  <= (state_s == DET_S4);
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/seq0011_scan_ctrl.sv
// Word-scan controller: accepts a parallel word, feeds it MSB-first into the
// "0011" detector core, counts matches and records where the first one ends.
module seq0011_scan_ctrl
    import seq0011_scan_ctrl_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] word_in,
    output logic              ser_bit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  first_idx
);

    localparam logic [CNT_W-1:0] IDX_NONE = {CNT_W{FIRST_IDX_NONE[0]}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t       state_r;
    ctrl_state_t       state_s;
    logic [WORD_W-1:0] shreg_r;
    logic [WORD_W-1:0] shreg_s;
    logic [CNT_W-1:0]  idx_r;
    logic [CNT_W-1:0]  idx_s;
    logic [CNT_W-1:0]  match_cnt_r;
    logic [CNT_W-1:0]  match_cnt_s;
    logic [CNT_W-1:0]  first_idx_r;
    logic [CNT_W-1:0]  first_idx_s;
    logic              en_d_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              ser_bit_r;
    logic              accept_s;
    logic              hit_s;
    logic              core_clr_s;
    logic              core_en_s;
    logic              core_dout_s;

    moore0011_core u_core (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (core_clr_s),
        .en     (core_en_s),
        .din    (shreg_r[WORD_W-1]),
        .dout   (core_dout_s)
    );

    // Controller sequencing: handshake, shift register and bit index.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        idx_s      = idx_r;
        accept_s   = 1'b0;
        core_clr_s = 1'b0;
        core_en_s  = 1'b0;
        case (state_r)
            CTRL_IDLE: begin
                if (in_valid) begin
                    accept_s   = 1'b1;
                    core_clr_s = 1'b1;
                    shreg_s    = word_in;
                    idx_s      = '0;
                    state_s    = CTRL_SHIFT;
                end else begin
                    state_s = CTRL_IDLE;
                end
            end
            CTRL_SHIFT: begin
                core_en_s = 1'b1;
                shreg_s   = {shreg_r[WORD_W-2:0], 1'b0};
                idx_s     = idx_r + ONE;
                if (idx_r == LAST_IDX) begin
                    state_s = CTRL_FLUSH;
                end else begin
                    state_s = CTRL_SHIFT;
                end
            end
            CTRL_FLUSH: state_s = CTRL_DONE;
            CTRL_DONE:  state_s = CTRL_IDLE;
            default:    state_s = CTRL_IDLE;
        endcase
    end

    // Result update: cleared on accept, bumped when the delayed core output fires.
    always_comb begin
        match_cnt_s = match_cnt_r;
        first_idx_s = first_idx_r;
        hit_s       = en_d_r & core_dout_s;
        if (accept_s) begin
            match_cnt_s = '0;
            first_idx_s = IDX_NONE;
        end else if (hit_s) begin
            match_cnt_s = match_cnt_r + ONE;
            // idx_r already points past the completing bit.
            if (first_idx_r == IDX_NONE) begin
                first_idx_s = idx_r - ONE;
            end else begin
                first_idx_s = first_idx_r;
            end
        end else begin
            match_cnt_s = match_cnt_r;
            first_idx_s = first_idx_r;
        end
    end

    // State, datapath and outputs, all registered from next-state values.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r     <= CTRL_IDLE;
            shreg_r     <= '0;
            idx_r       <= '0;
            match_cnt_r <= '0;
            first_idx_r <= IDX_NONE;
            en_d_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ser_bit_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            idx_r       <= idx_s;
            match_cnt_r <= match_cnt_s;
            first_idx_r <= first_idx_s;
            en_d_r      <= core_en_s;
            in_ready_r  <= (state_s == CTRL_IDLE);
            busy_r      <= (state_s == CTRL_SHIFT) || (state_s == CTRL_FLUSH);
            done_r      <= (state_s == CTRL_DONE);
            ser_bit_r   <= (state_s == CTRL_SHIFT) ? shreg_s[WORD_W-1] : 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ser_bit   = ser_bit_r;
    assign match_cnt = match_cnt_r;
    assign first_idx = first_idx_r;

endmodule

// File: tb/tb_seq0011_scan_ctrl.sv
// Self-checking bench for seq0011_scan_ctrl: directed words plus random words,
// each compared against a pattern-search reference model.
module tb_seq0011_scan_ctrl;

    logic        clk_in   = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] word_in  = 16'h0000;
    logic        in_ready;
    logic        ser_bit;
    logic        busy;
    logic        done;
    logic [4:0]  match_cnt;
    logic [4:0]  first_idx;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    seq0011_scan_ctrl #(.WORD_W(16), .CNT_W(5)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word_in   (word_in),
        .ser_bit   (ser_bit),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .first_idx (first_idx)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count every "0011" window in scan order (index k = bit 15-k).
    function automatic void ref_scan(input logic [15:0] w, output int cnt, output int first);
        cnt   = 0;
        first = 31;
        for (int k = 3; k < 16; k++) begin
            if (w[18-k] == 1'b0 && w[17-k] == 1'b0 && w[16-k] == 1'b1 && w[15-k] == 1'b1) begin
                cnt++;
                if (first == 31) first = k;
            end
        end
    endfunction

    // Scan one word from IDLE and check timing, debug bit and results.
    task automatic scan(input logic [15:0] w, input string tag);
        int   edges;
        int   j;
        int   cnt;
        int   first;
        logic ok_ctl;
        logic ok_ser;
        logic [4:0] m_hold;
        logic [4:0] f_hold;
        ref_scan(w, cnt, first);
        @(negedge clk_in);
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        word_in  = w;
        @(posedge clk_in);
        edges = 1;
        @(negedge clk_in);
        in_valid = 1'b0;
        word_in  = 16'($urandom);
        ok_ctl = 1'b1;
        ok_ser = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            j = edges - 1;
            if (busy !== 1'b1 || in_ready !== 1'b0) ok_ctl = 1'b0;
            if (j < 16) begin
                if (ser_bit !== w[15-j]) ok_ser = 1'b0;
            end else begin
                if (ser_bit !== 1'b0) ok_ser = 1'b0;
            end
            @(posedge clk_in);
            edges++;
            @(negedge clk_in);
        end
        check({tag, " latency"}, 32'(edges), 32'd18);
        check({tag, " busy/ready during scan"}, 32'(ok_ctl), 32'd1);
        check({tag, " ser_bit"}, 32'(ok_ser), 32'd1);
        check({tag, " done busy"}, 32'(busy), 32'd0);
        check({tag, " done in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " match_cnt"}, 32'(match_cnt), 32'(cnt));
        check({tag, " first_idx"}, 32'(first_idx), 32'(first));
        m_hold = 5'(cnt);
        f_hold = 5'(first);
        @(negedge clk_in);
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " back in idle"}, 32'(in_ready), 32'd1);
        check({tag, " match_cnt stable"}, 32'(match_cnt), 32'(m_hold));
        check({tag, " first_idx stable"}, 32'(first_idx), 32'(f_hold));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " ser_bit"}, 32'(ser_bit), 32'd0);
        check({tag, " match_cnt"}, 32'(match_cnt), 32'd0);
        check({tag, " first_idx"}, 32'(first_idx), 32'h1F);
    endtask

    initial begin
        int   acc[$];
        int   n_done;
        int   waited;
        logic ok_b2b;
        logic ok_rst;

        // Power-on reset, checked before the first clock edge.
        #1 reset = 1'b0;
        #2;
        check_reset_values("por");
        repeat (3) @(negedge clk_in);
        reset = 1'b1;

        // Directed words from the plan.
        scan(16'h3000, "w3000");
        scan(16'h3333, "w3333");
        scan(16'h0003, "w0003");
        scan(16'hFFFF, "wFFFF");
        scan(16'h0000, "w0000");
        scan(16'hC000, "wC000");

        // Back-to-back with in_valid held high.
        @(negedge clk_in);
        in_valid = 1'b1;
        word_in  = 16'h3333;
        n_done   = 0;
        ok_b2b   = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (in_ready === 1'b1) acc.push_back(cyc);
            if (done === 1'b1) begin
                n_done++;
                if (match_cnt !== 5'd4 || first_idx !== 5'd3) ok_b2b = 1'b0;
            end
            @(negedge clk_in);
        end
        in_valid = 1'b0;
        check("b2b accept count", 32'(acc.size()), 32'd4);
        if (acc.size() >= 3) begin
            check("b2b period 1", 32'(acc[1] - acc[0]), 32'd19);
            check("b2b period 2", 32'(acc[2] - acc[1]), 32'd19);
        end else begin
            check("b2b too few accepts", 32'(acc.size()), 32'd3);
        end
        check("b2b done count", 32'(n_done), 32'd3);
        check("b2b results", 32'(ok_b2b), 32'd1);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk_in);
            waited++;
        end
        check("b2b drain", 32'(in_ready), 32'd1);

        // Abort mid-scan at index 7.
        @(negedge clk_in);
        in_valid = 1'b1;
        word_in  = 16'h3333;
        @(posedge clk_in);
        @(negedge clk_in);
        in_valid = 1'b0;
        repeat (7) @(posedge clk_in);
        @(negedge clk_in);
        check("abort pre busy", 32'(busy), 32'd1);
        check("abort pre match_cnt", 32'(match_cnt), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_reset_values("abort");
        ok_rst = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            if (done !== 1'b0 || busy !== 1'b0) ok_rst = 1'b0;
        end
        check("abort no done", 32'(ok_rst), 32'd1);
        reset = 1'b1;
        scan(16'h3000, "after abort");

        // Random words against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (r % 4 == 0) w[11:8] = 4'b0011;
            scan(w, $sformatf("rand%0d_%04h", r, w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
